// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two combinational read ports and one write port.
// It also tracks which registers have been written since reset and keeps a saturating count of writes.
module reg_file #(
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       readReg1,
    input  logic [4:0]       readReg2,
    input  logic [4:0]       writeReg,
    input  logic [31:0]      writeData,
    input  logic             regWrite,
    output logic [31:0]      readData1,
    output logic [31:0]      readData2,
    output logic [31:0]      writtenMask,
    output logic [CNT_W-1:0] writeCount
);

    logic [31:0]      regs_q [32];
    logic [31:0]      mask_q, mask_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             writeEn;
    logic [4:0]       readIdx [2];
    logic [31:0]      readVal [2];

    // Index 0 is hardwired to zero, so a write aimed at it is dropped entirely.
    assign writeEn = regWrite && (writeReg != 5'd0);

    always_comb begin
        mask_d  = mask_q;
        count_d = count_q;
        if (writeEn) begin
            mask_d[writeReg] = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            if (writeEn) begin
                regs_q[writeReg] <= writeData;
            end
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    assign readIdx[0] = readReg1;
    assign readIdx[1] = readReg2;

    // Both ports apply the same priority: reset or index 0 forces zero, then forwarding, then storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            readVal[p] = regs_q[readIdx[p]];
            if (BYPASS && writeEn && (writeReg == readIdx[p])) begin
                readVal[p] = writeData;
            end
            if (!reset_n || (readIdx[p] == 5'd0)) begin
                readVal[p] = '0;
            end
        end
    end

    assign readData1   = readVal[0];
    assign readData2   = readVal[1];
    assign writtenMask = mask_q;
    assign writeCount  = count_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: three instances (forwarding, no forwarding, 4-bit counter)
// share one stimulus stream and are checked against an array-based reference model every cycle.
module tb_reg_file;

    logic        clk;
    logic        reset_n;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic        regWrite;

    logic [31:0] rdA1, rdA2, maskA;
    logic [15:0] cntA;
    logic [31:0] rdB1, rdB2, maskB;
    logic [15:0] cntB;
    logic [31:0] rdC1, rdC2, maskC;
    logic [3:0]  cntC;

    int nCompared;
    int nMismatched;
    bit checkEn;

    // Reference model: plain storage array, mask and an unbounded write tally.
    logic [31:0] mRegs [32];
    logic [31:0] mMask;
    int          mWrites;

    reg_file #(.BYPASS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readData1(rdA1), .readData2(rdA2), .writtenMask(maskA), .writeCount(cntA)
    );

    reg_file #(.BYPASS(1'b0), .CNT_W(16)) dutNoBypass (
        .clk(clk), .reset_n(reset_n), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readData1(rdB1), .readData2(rdB2), .writtenMask(maskB), .writeCount(cntB)
    );

    reg_file #(.BYPASS(1'b1), .CNT_W(4)) dutSmallCnt (
        .clk(clk), .reset_n(reset_n), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readData1(rdC1), .readData2(rdC2), .writtenMask(maskC), .writeCount(cntC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mRegs[i] <= '0;
            mMask   <= '0;
            mWrites <= 0;
        end else if (regWrite && writeReg != 5'd0) begin
            mRegs[writeReg]  <= writeData;
            mMask[writeReg]  <= 1'b1;
            mWrites          <= mWrites + 1;
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] idx, input bit fwd);
        if (!reset_n || idx == 5'd0) return 32'h0;
        if (fwd && regWrite && writeReg == idx) return writeData;
        return mRegs[idx];
    endfunction

    function automatic logic [31:0] expCount(input int width);
        int top;
        top = (1 << width) - 1;
        return 32'((mWrites > top) ? top : mWrites);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("A.readData1", rdA1, expRead(readReg1, 1'b1));
            checkOutput("A.readData2", rdA2, expRead(readReg2, 1'b1));
            checkOutput("A.mask", maskA, mMask);
            checkOutput("A.count", 32'(cntA), expCount(16));
            checkOutput("B.readData1", rdB1, expRead(readReg1, 1'b0));
            checkOutput("B.readData2", rdB2, expRead(readReg2, 1'b0));
            checkOutput("B.count", 32'(cntB), expCount(16));
            checkOutput("C.readData1", rdC1, expRead(readReg1, 1'b1));
            checkOutput("C.mask", maskC, mMask);
            checkOutput("C.count", 32'(cntC), expCount(4));
        end
    end

    task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                                 input logic [31:0] d, input logic we);
        @(posedge clk);
        #2;
        readReg1  = r1;
        readReg2  = r2;
        writeReg  = w;
        writeData = d;
        regWrite  = we;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        checkEn     = 1'b0;
        reset_n     = 1'b0;
        readReg1    = '0;
        readReg2    = '0;
        writeReg    = '0;
        writeData   = '0;
        regWrite    = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        checkEn = 1'b1;

        // Populate a few registers so the reset pulse has something to clear.
        for (int i = 1; i < 8; i++) applyStimulus(5'(i), 5'(i), 5'(i), 32'h100 + 32'(i), 1'b1);
        applyStimulus(5'd3, 5'd4, 5'd0, 32'h0, 1'b0);

        // Reset pulsed between edges, then every index must read back zero.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("lowReset.readData1", rdA1, 32'h0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);
            settle();
            checkOutput("afterReset.readData1", rdA1, 32'h0);
            checkOutput("afterReset.readData2", rdA2, 32'h0);
        end
        checkOutput("afterReset.mask", maskA, 32'h0);
        checkOutput("afterReset.count", 32'(cntA), 32'h0);

        applyStimulus(5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(5'd5, 5'd5, 5'd0, 32'h0, 1'b0);
        settle();
        checkOutput("wr5.readData1", rdA1, 32'hDEAD_BEEF);
        checkOutput("wr5.readData2", rdA2, 32'hDEAD_BEEF);
        checkOutput("wr5.mask", maskA, 32'h0000_0020);
        checkOutput("wr5.count", 32'(cntA), 32'd1);

        applyStimulus(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        settle();
        checkOutput("wr0.readData1", rdA1, 32'h0);
        checkOutput("wr0.mask", maskA, 32'h0000_0020);
        checkOutput("wr0.count", 32'(cntA), 32'd1);

        applyStimulus(5'd0, 5'd0, 5'd7, 32'h1, 1'b1);
        applyStimulus(5'd7, 5'd7, 5'd7, 32'h2, 1'b1);
        settle();
        checkOutput("bypass.fwd.readData1", rdA1, 32'h2);
        checkOutput("bypass.fwd.readData2", rdA2, 32'h2);
        checkOutput("bypass.nofwd.readData1", rdB1, 32'h1);
        applyStimulus(5'd7, 5'd7, 5'd0, 32'h0, 1'b0);
        settle();
        checkOutput("bypass.nofwd.after", rdB1, 32'h2);
        checkOutput("bypass.count", 32'(cntA), 32'd3);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd1, 5'd2, 5'($urandom_range(1, 31)), $urandom, 1'b1);
        end
        applyStimulus(5'd1, 5'd2, 5'd0, 32'h0, 1'b0);
        settle();
        checkOutput("sat.smallCount", 32'(cntC), 32'd15);
        checkOutput("sat.wideCount", 32'(cntA), 32'd23);
        applyStimulus(5'd1, 5'd2, 5'd9, 32'h9, 1'b1);
        applyStimulus(5'd1, 5'd2, 5'd0, 32'h0, 1'b0);
        settle();
        checkOutput("sat.hold", 32'(cntC), 32'd15);

        // Reset lands on the same edge as a write to index 3; that write must vanish.
        applyStimulus(5'd3, 5'd3, 5'd3, 32'hA5A5_A5A5, 1'b1);
        @(negedge clk);
        #3 reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n  = 1'b1;
        regWrite = 1'b0;
        settle();
        checkOutput("midReset.readData1", rdA1, 32'h0);
        checkOutput("midReset.mask3", 32'(maskA[3]), 32'h0);
        checkOutput("midReset.count", 32'(cntA), 32'h0);

        // Randomised traffic with biased read/write index collisions and sparse reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] w;
            logic [4:0] r1;
            logic [4:0] r2;
            w  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) w = 5'd0;
            r1 = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            applyStimulus(r1, r2, w, $urandom, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 59) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        settle();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
